// File: rtl/scc_slot_pkg.sv
// Shared types and address-decode constants for the SCC cartridge slot front end.
package scc_slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

    localparam logic [15:0] DEC_MASK   = 16'hF800;
    localparam logic [15:0] BANK0_BASE = 16'h5000;
    localparam logic [15:0] BANK1_BASE = 16'h7000;
    localparam logic [15:0] BANK2_BASE = 16'h9000;
    localparam logic [15:0] BANK3_BASE = 16'hB000;
    localparam logic [15:0] SCC_BASE   = 16'h9800;

    // Byte i holds the reset value of bank i.
    localparam logic [31:0] BANK_RST = {8'd3, 8'd2, 8'd1, 8'd0};

    // Only slot_a[15:11] is kept after capture; this compares that tag to a 2 KB window.
    function automatic logic tag_hit(input logic [4:0] tag, input logic [15:0] base);
        return (({tag, 11'd0} & DEC_MASK) == base);
    endfunction

endpackage

// File: rtl/scc_slot_sync.sv
// Multi-stage synchronizer for one asynchronous slot strobe; resets to the inactive (1) level.
module scc_slot_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/scc_slot_interface.sv
// MSX slot front end for the SCC: strobe sync, Konami-SCC bank mapper, SCC register strobes.
module scc_slot_interface
    import scc_slot_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [5:0] SCC_EN_VALUE = 6'h3F
) (
    input  logic        clk,
    input  logic        slot_nreset,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    input  logic        slot_nsltsl,
    input  logic        slot_nmerq,
    input  logic        slot_nrd,
    input  logic        slot_nwr,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    output logic        mem_ncs,
    output logic [7:0]  mem_a,
    output logic        reg_wr,
    output logic        reg_rd,
    output logic [7:0]  reg_address,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata
);

    localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

    logic s_nsltsl, s_nmerq, s_nrd, s_nwr;

    scc_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_nsltsl (.clk(clk), .rst_n(slot_nreset), .d(slot_nsltsl), .q(s_nsltsl));
    scc_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_nmerq  (.clk(clk), .rst_n(slot_nreset), .d(slot_nmerq),  .q(s_nmerq));
    scc_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_nrd    (.clk(clk), .rst_n(slot_nreset), .d(slot_nrd),    .q(s_nrd));
    scc_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_nwr    (.clk(clk), .rst_n(slot_nreset), .d(slot_nwr),    .q(s_nwr));

    state_t     state, state_next;
    logic [7:0] bank [4];
    logic [4:0] cap_tag;
    logic [1:0] settle_cnt;
    logic       armed;
    logic       rd_pending;
    logic [7:0] dout_q;

    logic acc, start_wr, start_rd, bus_end, scc_hit, rom_hit;
    logic [1:0] rom_sel;

    assign acc      = ~s_nsltsl & ~s_nmerq;
    assign start_wr = armed & acc & ~s_nwr;
    assign start_rd = armed & acc & ~s_nrd & s_nwr;
    assign bus_end  = (s_nwr & s_nrd) | s_nsltsl | s_nmerq;
    assign scc_hit  = tag_hit(cap_tag, SCC_BASE) & (bank[2][5:0] == SCC_EN_VALUE);
    assign rom_hit  = (cap_tag[4:3] == 2'b01) | (cap_tag[4:3] == 2'b10);
    assign rom_sel  = cap_tag[3:2] - 2'd2;

    // A strobe still low when reset releases must not start an access: accept strobes
    // only after the synchronizers have flushed and both strobes were seen idle once.
    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else if (settle_cnt != SETTLE) begin
            settle_cnt <= settle_cnt + 2'd1;
        end else if (s_nwr & s_nrd) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) state <= ST_IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_wr)      state_next = ST_WRITE;
                else if (start_rd) state_next = ST_READ;
            end
            ST_WRITE:    state_next = ST_WAIT_END;
            ST_READ:     state_next = ST_WAIT_END;
            ST_WAIT_END: if (bus_end) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // reg_wr/reg_rd are one-clock strobes with no back-pressure: the core must accept a
    // write in the strobe clock and present reg_rdata in the clock after reg_rd.
    always_comb begin
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        case (state)
            ST_WRITE: reg_wr = scc_hit;
            ST_READ:  reg_rd = scc_hit;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            for (int i = 0; i < 4; i++) bank[i] <= BANK_RST[i*8 +: 8];
            cap_tag     <= 5'd0;
            reg_address <= 8'd0;
            reg_wdata   <= 8'd0;
            mem_ncs     <= 1'b1;
            mem_a       <= 8'd0;
            slot_d_oe   <= 1'b0;
            rd_pending  <= 1'b0;
            dout_q      <= 8'd0;
        end else begin
            rd_pending <= reg_rd;
            if (rd_pending) dout_q <= reg_rdata;
            if (state == ST_IDLE && (start_wr || start_rd)) begin
                cap_tag     <= slot_a[15:11];
                reg_address <= slot_a[7:0];
                if (start_wr) reg_wdata <= slot_d_in;
            end
            if (state == ST_WRITE) begin
                if (tag_hit(cap_tag, BANK0_BASE)) bank[0] <= reg_wdata;
                if (tag_hit(cap_tag, BANK1_BASE)) bank[1] <= reg_wdata;
                if (tag_hit(cap_tag, BANK2_BASE)) bank[2] <= reg_wdata;
                if (tag_hit(cap_tag, BANK3_BASE)) bank[3] <= reg_wdata;
            end
            if (state == ST_READ) begin
                if (scc_hit) begin
                    slot_d_oe <= 1'b1;
                end else if (rom_hit) begin
                    mem_ncs <= 1'b0;
                    mem_a   <= bank[rom_sel];
                end
            end
            if (state == ST_WAIT_END && bus_end) begin
                mem_ncs   <= 1'b1;
                slot_d_oe <= 1'b0;
            end
        end
    end

    // reg_rdata is passed straight through in its valid clock, then held from the latch.
    assign slot_d_out = rd_pending ? reg_rdata : dout_q;

endmodule

// File: tb/tb_scc_slot_interface.sv
// Bench for scc_slot_interface: directed vector table, hand-written reset sequences, random accesses.
module tb_scc_slot_interface;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        slot_nreset;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_in;
    logic        slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe, mem_ncs, reg_wr, reg_rd;
    logic [7:0]  mem_a, reg_address, reg_wdata;
    logic [7:0]  reg_rdata = 8'd0;

    scc_slot_interface #(.SYNC_STAGES(SS), .SCC_EN_VALUE(6'h3F)) dut (
        .clk(clk), .slot_nreset(slot_nreset), .slot_a(slot_a), .slot_d_in(slot_d_in),
        .slot_nsltsl(slot_nsltsl), .slot_nmerq(slot_nmerq), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr),
        .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe), .mem_ncs(mem_ncs), .mem_a(mem_a),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_address(reg_address), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Strobe monitor: totals and details of the most recent pulses
    int         wr_total = 0, rd_total = 0, wr_cyc = 0, rd_cyc = 0;
    logic [7:0] wr_addr, wr_data, rd_addr;
    always @(negedge clk) begin
        if (reg_wr) begin wr_total++; wr_cyc = cyc; wr_addr = reg_address; wr_data = reg_wdata; end
        if (reg_rd) begin rd_total++; rd_cyc = cyc; rd_addr = reg_address; end
    end

    // SCC core stand-in: the requested value is valid only around the clock after reg_rd
    logic [7:0] scc_val = 8'd0;
    bit         scc_hold = 1'b0;
    always @(negedge clk) begin
        if (reg_rd) begin
            reg_rdata = scc_val;
            scc_hold  = 1'b1;
        end else if (scc_hold) begin
            scc_hold = 1'b0;
        end else begin
            reg_rdata = 8'($urandom);
        end
    end

    // Reference model: mapper state as a plain array
    logic [7:0] m_bank [4];
    logic [7:0] m_mem_a;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = 8'(i);
        m_mem_a = 8'd0;
    endfunction

    function automatic bit model_win(input logic [15:0] a);
        return (a >= 16'h9800 && a <= 16'h9FFF) && (m_bank[2][5:0] == 6'h3F);
    endfunction

    function automatic bit model_rom(input logic [15:0] a);
        return (a >= 16'h4000 && a <= 16'hBFFF);
    endfunction

    function automatic void model_commit(input bit wr, input logic [15:0] a, input logic [7:0] d);
        int idx;
        if (!wr && model_rom(a) && !model_win(a)) begin
            idx = (int'(a) - 'h4000) / 'h2000;
            m_mem_a = m_bank[idx];
        end
        if (wr) begin
            if (a >= 16'h5000 && a <= 16'h57FF) m_bank[0] = d;
            if (a >= 16'h7000 && a <= 16'h77FF) m_bank[1] = d;
            if (a >= 16'h9000 && a <= 16'h97FF) m_bank[2] = d;
            if (a >= 16'hB000 && a <= 16'hB7FF) m_bank[3] = d;
        end
    endfunction

    // Driver: one full Z80-style bus cycle with checks of every observable effect
    task automatic run_access(input bit wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rv,
                              input logic e_ncs, input logic [7:0] e_mem_a, input logic e_oe,
                              input int e_wr, input int e_rd);
        int c0, wb, rb;
        @(negedge clk);
        slot_a = a; slot_d_in = d; scc_val = rv;
        slot_nsltsl = 1'b0; slot_nmerq = 1'b0;
        if (wr) slot_nwr = 1'b0; else slot_nrd = 1'b0;
        c0 = cyc; wb = wr_total; rb = rd_total;
        repeat (6) @(negedge clk);
        check("mem_ncs", mem_ncs, e_ncs);
        check("mem_a", mem_a, e_mem_a);
        check("slot_d_oe", slot_d_oe, e_oe);
        if (e_oe) check("slot_d_out", slot_d_out, rv);
        slot_nwr = 1'b1; slot_nrd = 1'b1;
        repeat (SS + 1) @(negedge clk);
        check("mem_ncs_release", mem_ncs, 1'b1);
        check("slot_d_oe_release", slot_d_oe, 1'b0);
        slot_nsltsl = 1'b1; slot_nmerq = 1'b1;
        slot_a = 16'($urandom); slot_d_in = 8'($urandom);
        repeat (2) @(negedge clk);
        check("reg_wr_pulses", wr_total - wb, e_wr);
        check("reg_rd_pulses", rd_total - rb, e_rd);
        if (e_wr == 1) begin
            check("reg_wr_latency", wr_cyc - c0, SS + 1);
            check("reg_wr_address", wr_addr, a[7:0]);
            check("reg_wr_data", wr_data, d);
        end
        if (e_rd == 1) begin
            check("reg_rd_latency", rd_cyc - c0, SS + 1);
            check("reg_rd_address", rd_addr, a[7:0]);
        end
    endtask

    task automatic model_access(input bit wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rv);
        bit   win, rom;
        logic e_ncs;
        win   = model_win(a);
        rom   = model_rom(a);
        e_ncs = !(!wr && rom && !win);
        model_commit(wr, a, d);
        run_access(wr, a, d, rv, e_ncs, m_mem_a, !wr && win, (wr && win) ? 1 : 0, (!wr && win) ? 1 : 0);
    endtask

    typedef struct {
        bit         wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rv;
        logic        e_ncs;
        logic [7:0]  e_mem_a;
        logic        e_oe;
        int          e_wr;
        int          e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rv,
                                input logic ncs, input logic [7:0] ma, input logic oe, input int nw, input int nr);
        vec_t v;
        v = '{wr, a, d, rv, ncs, ma, oe, nw, nr};
        vecs.push_back(v);
    endfunction

    initial begin
        //  wr  addr      data   rdata  ncs   mem_a  oe    wr rd
        add(0, 16'h4000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0);
        add(0, 16'h6000, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 0, 0);
        add(0, 16'h8000, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 0, 0);
        add(0, 16'hBFFF, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 0, 0);
        add(1, 16'h9000, 8'h3F, 8'h00, 1'b1, 8'h03, 1'b0, 0, 0);
        add(1, 16'h9880, 8'hFE, 8'h00, 1'b1, 8'h03, 1'b0, 1, 0);
        add(0, 16'h9810, 8'h00, 8'hA5, 1'b1, 8'h03, 1'b1, 0, 1);
        add(1, 16'h9000, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0, 0, 0);
        add(1, 16'h988A, 8'h0F, 8'h00, 1'b1, 8'h03, 1'b0, 0, 0);
        add(0, 16'h9810, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0);
        add(1, 16'h7000, 8'h05, 8'h00, 1'b1, 8'h00, 1'b0, 0, 0);
        add(0, 16'h6123, 8'h00, 8'h00, 1'b0, 8'h05, 1'b0, 0, 0);
        add(0, 16'h3FFF, 8'h00, 8'h00, 1'b1, 8'h05, 1'b0, 0, 0);
        add(0, 16'hC000, 8'h00, 8'h00, 1'b1, 8'h05, 1'b0, 0, 0);
        add(1, 16'h57FF, 8'h12, 8'h00, 1'b1, 8'h05, 1'b0, 0, 0);
        add(0, 16'h4000, 8'h00, 8'h00, 1'b0, 8'h12, 1'b0, 0, 0);
        add(1, 16'h5800, 8'h77, 8'h00, 1'b1, 8'h12, 1'b0, 0, 0);
        add(0, 16'h5FFF, 8'h00, 8'h00, 1'b0, 8'h12, 1'b0, 0, 0);
        add(1, 16'h9000, 8'h3F, 8'h00, 1'b1, 8'h12, 1'b0, 0, 0);
        add(1, 16'h9FFF, 8'h5A, 8'h00, 1'b1, 8'h12, 1'b0, 1, 0);
        add(1, 16'h97FF, 8'h7F, 8'h00, 1'b1, 8'h12, 1'b0, 0, 0);
        add(1, 16'h9800, 8'h11, 8'h00, 1'b1, 8'h12, 1'b0, 1, 0);
        add(0, 16'h9A00, 8'h00, 8'h3C, 1'b1, 8'h12, 1'b1, 0, 1);
        add(0, 16'hA000, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 0, 0);
        add(1, 16'hB7FF, 8'h44, 8'h00, 1'b1, 8'h03, 1'b0, 0, 0);
        add(0, 16'hBFFF, 8'h00, 8'h00, 1'b0, 8'h44, 1'b0, 0, 0);

        // Reset held for 50 clocks with the bus idle
        slot_nreset = 1'b0;
        slot_a = 16'h0000; slot_d_in = 8'h00;
        slot_nsltsl = 1'b1; slot_nmerq = 1'b1; slot_nrd = 1'b1; slot_nwr = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_mem_ncs", mem_ncs, 1'b1);
        check("rst_mem_a", mem_a, 8'h00);
        check("rst_slot_d_oe", slot_d_oe, 1'b0);
        check("rst_slot_d_out", slot_d_out, 8'h00);
        check("rst_reg_address", reg_address, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        slot_nreset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_strobes", wr_total + rd_total, 0);
        model_reset();

        // Directed table; the model follows along so the random phase starts in sync
        foreach (vecs[i]) begin
            run_access(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rv, vecs[i].e_ncs,
                       vecs[i].e_mem_a, vecs[i].e_oe, vecs[i].e_wr, vecs[i].e_rd);
            model_commit(vecs[i].wr, vecs[i].a, vecs[i].d);
        end

        // Reset pulled mid-write and released while the write strobe is still low
        begin
            int wb;
            @(negedge clk);
            slot_a = 16'h7000; slot_d_in = 8'h09;
            slot_nsltsl = 1'b0; slot_nmerq = 1'b0; slot_nwr = 1'b0;
            wb = wr_total;
            @(negedge clk);
            slot_nreset = 1'b0;
            repeat (3) @(negedge clk);
            check("midrst_mem_ncs", mem_ncs, 1'b1);
            check("midrst_mem_a", mem_a, 8'h00);
            slot_nreset = 1'b1;
            repeat (8) @(negedge clk);
            check("midrst_reg_address", reg_address, 8'h00);
            check("midrst_reg_wdata", reg_wdata, 8'h00);
            slot_nwr = 1'b1; slot_nsltsl = 1'b1; slot_nmerq = 1'b1;
            repeat (4) @(negedge clk);
            check("midrst_no_reg_wr", wr_total - wb, 0);
            model_reset();
            model_access(0, 16'h6000, 8'h00, 8'h00);
            model_access(1, 16'h9000, 8'h3F, 8'h00);
            model_access(1, 16'h9880, 8'hFE, 8'h00);
        end

        // Randomized accesses against the model
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            bit          wr;
            int          sel;
            sel = $urandom_range(0, 7);
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            case (sel)
                0:       a = 16'h5000 + 16'($urandom_range(0, 'h7FF));
                1:       a = 16'h7000 + 16'($urandom_range(0, 'h7FF));
                2: begin a = 16'h9000 + 16'($urandom_range(0, 'h7FF)); d = {2'($urandom), 6'h3F}; end
                3:       a = 16'hB000 + 16'($urandom_range(0, 'h7FF));
                4, 5:    a = 16'h9800 + 16'($urandom_range(0, 'h7FF));
                6:       a = 16'h4000 + 16'($urandom_range(0, 'h7FFF));
                default: a = 16'($urandom);
            endcase
            model_access(wr, a, d, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
